// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the iterative 32-bit divider.
// State encodings, datapath widths and sign-conditioning functions.
package div_unit_pkg;

   localparam int DIV_W = 32;
   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] DIV_LAST = 6'd31;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // |0x80000000| stays 0x80000000, which is correct read as an unsigned magnitude.
   function automatic logic [DIV_W-1:0] abs_if(input logic [DIV_W-1:0] v, input logic sgn);
      abs_if = (sgn && v[DIV_W-1]) ? -v : v;
   endfunction

   function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic neg);
      neg_if = neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between EX-stage control and the divider.
// start is a request sampled only while the divider is idle; there is no back-pressure.
// ready is a one-cycle completion pulse with result valid alongside it; result then holds.
// annul drops whatever is in flight and returns the unit to idle without a ready pulse.
interface div_unit_if;
   import div_unit_pkg::*;

   logic [DIV_W-1:0]   a;
   logic [DIV_W-1:0]   b;
   logic               signed_div;
   logic               start;
   logic               annul;
   logic               busy;
   logic               ready;
   logic [2*DIV_W-1:0] result;
   div_state_e         state;

   modport master (
      output a, b, signed_div, start, annul,
      input  busy, ready, result, state
   );

   modport slave (
      input  a, b, signed_div, start, annul,
      output busy, ready, result, state
   );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider: 32 iterations, one per cycle, result = {remainder, quotient}.
// Signed division runs on magnitudes; signs are reapplied when the last iteration retires.
module div_unit
   import div_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   rem_q, rem_d;
   logic [DIV_W-1:0]   quo_q, quo_d;
   logic [DIV_W-1:0]   dvs_q, dvs_d;
   logic               quo_neg_q, quo_neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [2*DIV_W-1:0] result_q, result_d;

   logic [DIV_W:0]     rem_sh;
   logic [DIV_W-1:0]   quo_sh;
   logic [DIV_W:0]     trial;
   logic [DIV_W-1:0]   rem_nxt;
   logic [DIV_W-1:0]   quo_nxt;

   // The kept remainder is always below the divisor, so its bit 32 is zero and is not
   // stored; the 33-bit width only matters for the shifted value and the trial subtract.
   always_comb begin
      rem_sh  = {rem_q, quo_q[DIV_W-1]};
      quo_sh  = {quo_q[DIV_W-2:0], 1'b0};
      trial   = rem_sh - {1'b0, dvs_q};
      rem_nxt = trial[DIV_W] ? rem_sh[DIV_W-1:0] : trial[DIV_W-1:0];
      quo_nxt = {quo_sh[DIV_W-1:1], ~trial[DIV_W]};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;

      unique case (state_q)
         DIV_IDLE: begin
            if (bus.start) begin
               if (bus.b == '0) begin
                  result_d = '0;
                  state_d  = DIV_DONE;
               end else begin
                  rem_d     = '0;
                  quo_d     = abs_if(bus.a, bus.signed_div);
                  dvs_d     = abs_if(bus.b, bus.signed_div);
                  quo_neg_d = bus.signed_div & (bus.a[DIV_W-1] ^ bus.b[DIV_W-1]);
                  rem_neg_d = bus.signed_div & bus.a[DIV_W-1];
                  cnt_d     = '0;
                  state_d   = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DIV_LAST) begin
               result_d = {neg_if(rem_nxt, rem_neg_q), neg_if(quo_nxt, quo_neg_q)};
               cnt_d    = '0;
               state_d  = DIV_DONE;
            end
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A flush from a later stage wins over any request or completion in flight.
      if (bus.annul) begin
         state_d  = DIV_IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
      end
   end

   assign bus.busy   = (state_q == DIV_RUN);
   assign bus.ready  = (state_q == DIV_DONE);
   assign bus.result = result_q;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder pairs, latency,
// busy/ready framing, annul, mid-run reset and ignored requests.
module tb_div_unit;
   import div_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_res;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and follows it to completion; noisy scrambles start and the
   // operands during RUN and DONE, which must not disturb the answer or the framing.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input bit noisy);
      int          lat;
      int          nbusy;
      logic [63:0] e;
      exp_q.push_back(exp);
      bus.a          = a;
      bus.b          = b;
      bus.signed_div = sgn;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!bus.ready && lat < 64) begin
         if (bus.busy) nbusy++;
         if (noisy) begin
            bus.start      = ~bus.start;
            bus.a          = ~bus.a;
            bus.b          = bus.b ^ 32'h0000_0005;
            bus.signed_div = ~bus.signed_div;
         end
         tick();
         lat++;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      check_eq("ready_pulse", 64'(bus.ready), 64'd1);
      check_eq("latency", 64'(lat), (b == 32'd0) ? 64'd0 : 64'd32);
      check_eq("busy_cycles", 64'(nbusy), (b == 32'd0) ? 64'd0 : 64'd32);
      check_eq("result", bus.result, e);
      if (noisy) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("ready_drop", 64'(bus.ready), 64'd0);
      check_eq("idle_after", 64'(bus.busy), 64'd0);
      last_res = e;
   endtask

   initial begin
      int nrdy;
      int nbsy;
      rst            = 1'b1;
      bus.a          = '0;
      bus.b          = '0;
      bus.signed_div = 1'b0;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_ready", 64'(bus.ready), 64'd0);
      check_eq("rst_result", bus.result, 64'd0);
      check_eq("rst_state", 64'(bus.state), 64'(DIV_IDLE));

      run_div(32'd100,       32'd7,         1'b0, {32'd2,         32'd14},        1'b0);
      run_div(32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
      run_div(32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
      run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 1'b0);
      run_div(32'hFFFF_FFF9, 32'd2,         1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 1'b0);
      run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h0000_0001}, 1'b0);
      run_div(32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 1'b0);

      // annul sampled at E10, the tenth iteration edge
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.annul = 1'b1;
      tick();
      bus.annul = 1'b0;
      check_eq("annul_busy", 64'(bus.busy), 64'd0);
      check_eq("annul_ready", 64'(bus.ready), 64'd0);
      check_eq("annul_state", 64'(bus.state), 64'(DIV_IDLE));
      check_eq("annul_result", bus.result, last_res);
      nrdy = 0;
      nbsy = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.ready) nrdy++;
         if (bus.busy) nbsy++;
         tick();
      end
      check_eq("annul_no_ready", 64'(nrdy), 64'd0);
      check_eq("annul_no_busy", 64'(nbsy), 64'd0);

      // annul together with start in IDLE drops the request
      bus.a = 32'd5; bus.b = 32'd0; bus.start = 1'b1; bus.annul = 1'b1;
      tick();
      check_eq("drop_dz_ready", 64'(bus.ready), 64'd0);
      check_eq("drop_dz_result", bus.result, last_res);
      bus.b = 32'd7;
      tick();
      bus.start = 1'b0; bus.annul = 1'b0;
      check_eq("drop_busy", 64'(bus.busy), 64'd0);

      run_div(32'd5, 32'd0, 1'b0, 64'd0, 1'b0);
      run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);

      // reset in the middle of a run
      bus.a = 32'hFFFF_FFFF; bus.b = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_busy", 64'(bus.busy), 64'd0);
      check_eq("midrst_ready", 64'(bus.ready), 64'd0);
      check_eq("midrst_result", bus.result, 64'd0);
      check_eq("midrst_state", 64'(bus.state), 64'(DIV_IDLE));

      run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
      run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b1);
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
